// File: rtl/s_chunk_feeder_pkg.sv
// Shared constants for the query (S) chunk path.
// Chunk geometry, base codes and feeder states.
package s_chunk_feeder_pkg;

  localparam int PE_ARRAY_SIZE = 64;
  localparam int PE_ARRAY_SIZE_LOG = 6;
  localparam int CHUNK_CNT_W = PE_ARRAY_SIZE_LOG + 1;

  localparam int BASE_W = 2;
  localparam logic [BASE_W-1:0] BASE_A = 2'd0;
  localparam logic [BASE_W-1:0] BASE_C = 2'd1;
  localparam logic [BASE_W-1:0] BASE_G = 2'd2;
  localparam logic [BASE_W-1:0] BASE_T = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/s_chunk_packer.sv
// One ping-pong entry: packs bases MSB-first into a chunk,
// flags full on N bases or the last base, clears on read.
import s_chunk_feeder_pkg::*;

module s_chunk_packer #(
  parameter int N = 64,
  parameter int LOG = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [BASE_W-1:0] wr_base,
  input  logic              wr_last,
  input  logic              rd_en,
  output logic [2*N-1:0]    data,
  output logic [LOG:0]      count,
  output logic              last,
  output logic              full,
  output logic              done
);

  logic [LOG-1:0] slot;
  logic [LOG:0]   cnt_inc;
  logic [2*N-1:0] ins;

  assign slot    = count[LOG-1:0];
  assign cnt_inc = count + 1'b1;
  assign done    = wr_en
                 & ((cnt_inc == (LOG+1)'(N))
                 | wr_last);

  // drop the incoming base into its slot
  always_comb begin
    ins = data;
    for (int k = 0; k < N; k++) begin
      if (slot == LOG'(k))
        ins[2*N-1-2*k -: 2] = wr_base;
    end
  end

  // entry registers; a read empties the entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      count <= '0;
      last  <= 1'b0;
      full  <= 1'b0;
    end else if (clr | rd_en) begin
      data  <= '0;
      count <= '0;
      last  <= 1'b0;
      full  <= 1'b0;
    end else if (wr_en) begin
      data  <= ins;
      count <= cnt_inc;
      if (done) begin
        full <= 1'b1;
        last <= wr_last;
      end
    end
  end

endmodule

// File: rtl/s_chunk_feeder.sv
// Query feeder: fills a 2-entry ping-pong of chunks
// from the host and hands one chunk per request.
import s_chunk_feeder_pkg::*;

module s_chunk_feeder #(
  parameter int PE_ARRAY_SIZE =
    s_chunk_feeder_pkg::PE_ARRAY_SIZE,
  parameter int PE_ARRAY_SIZE_LOG =
    s_chunk_feeder_pkg::PE_ARRAY_SIZE_LOG
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_base_valid,
  input  logic [1:0] i_base,
  input  logic i_base_last,
  output logic o_base_ready,
  input  logic i_request,
  output logic [2*PE_ARRAY_SIZE-1:0] o_s,
  output logic [PE_ARRAY_SIZE_LOG:0] o_s_valid,
  output logic o_s_last,
  output logic o_busy
);

  localparam int N  = PE_ARRAY_SIZE;
  localparam int LG = PE_ARRAY_SIZE_LOG;

  state_t state, state_nxt;
  logic wr_ptr, rd_ptr, pending;
  logic start, accept, rd_fire;
  logic wr_full, rd_full, rd_last;
  logic [2*N-1:0] data0, data1, rd_data;
  logic [LG:0] cnt0, cnt1, rd_cnt;
  logic last0, last1, full0, full1;
  logic done0, done1;

  assign start   = (state == ST_IDLE) & i_start;
  assign wr_full = wr_ptr ? full1 : full0;
  assign o_base_ready = (state == ST_FILL) & ~wr_full;
  assign accept  = i_base_valid & o_base_ready;

  assign rd_full = rd_ptr ? full1 : full0;
  assign rd_last = rd_ptr ? last1 : last0;
  assign rd_cnt  = rd_ptr ? cnt1 : cnt0;
  assign rd_data = rd_ptr ? data1 : data0;
  assign rd_fire = (state != ST_IDLE)
                 & (pending | i_request)
                 & rd_full;

  s_chunk_packer #(.N(N), .LOG(LG)) u_pk0 (
    .clk(clk), .rst_n(rst_n), .clr(start),
    .wr_en(accept & ~wr_ptr),
    .wr_base(i_base), .wr_last(i_base_last),
    .rd_en(rd_fire & ~rd_ptr),
    .data(data0), .count(cnt0), .last(last0),
    .full(full0), .done(done0)
  );

  s_chunk_packer #(.N(N), .LOG(LG)) u_pk1 (
    .clk(clk), .rst_n(rst_n), .clr(start),
    .wr_en(accept & wr_ptr),
    .wr_base(i_base), .wr_last(i_base_last),
    .rd_en(rd_fire & rd_ptr),
    .data(data1), .count(cnt1), .last(last1),
    .full(full1), .done(done1)
  );

  // next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_FILL;
      ST_FILL:  if (accept & i_base_last)
                  state_nxt = ST_DRAIN;
      ST_DRAIN: if (rd_fire & rd_last)
                  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // state, pointers and the latched request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        wr_ptr  <= 1'b0;
        rd_ptr  <= 1'b0;
        pending <= 1'b0;
      end else begin
        if (done0 | done1) wr_ptr <= ~wr_ptr;
        if (rd_fire) rd_ptr <= ~rd_ptr;
        if ((state == ST_IDLE) | rd_fire)
          pending <= 1'b0;
        else if (i_request)
          pending <= 1'b1;
      end
    end
  end

  // registered chunk delivery and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_s       <= '0;
      o_s_valid <= '0;
      o_s_last  <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_s_valid <= '0;
      o_s_last  <= 1'b0;
      o_busy    <= (state_nxt != ST_IDLE);
      if (rd_fire) begin
        o_s       <= rd_data;
        o_s_valid <= rd_cnt;
        o_s_last  <= rd_last;
      end
    end
  end

endmodule

// File: tb/tb_s_chunk_feeder.sv
// Directed bench for s_chunk_feeder at N=4,
// plus a short N=64 packing check.
module tb_s_chunk_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic i_start, i_base_valid, i_base_last;
  logic [1:0] i_base;
  logic o_base_ready, i_request;
  logic [7:0] o_s;
  logic [2:0] o_s_valid;
  logic o_s_last, o_busy;

  logic w_start, w_valid, w_last, w_ready;
  logic [1:0] w_base;
  logic w_request;
  logic [127:0] w_s;
  logic [6:0] w_s_valid;
  logic w_s_last, w_busy;

  s_chunk_feeder #(
    .PE_ARRAY_SIZE(4), .PE_ARRAY_SIZE_LOG(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_start(i_start),
    .i_base_valid(i_base_valid),
    .i_base(i_base),
    .i_base_last(i_base_last),
    .o_base_ready(o_base_ready),
    .i_request(i_request),
    .o_s(o_s), .o_s_valid(o_s_valid),
    .o_s_last(o_s_last), .o_busy(o_busy)
  );

  s_chunk_feeder #(
    .PE_ARRAY_SIZE(64), .PE_ARRAY_SIZE_LOG(6)
  ) dut64 (
    .clk(clk), .rst_n(rst_n),
    .i_start(w_start),
    .i_base_valid(w_valid),
    .i_base(w_base),
    .i_base_last(w_last),
    .o_base_ready(w_ready),
    .i_request(w_request),
    .o_s(w_s), .o_s_valid(w_s_valid),
    .o_s_last(w_s_last), .o_busy(w_busy)
  );

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  logic [7:0] q_s[$];
  int q_v[$];
  int q_l[$];

  always @(negedge clk) begin
    if (rst_n && o_s_valid != 0) begin
      q_s.push_back(o_s);
      q_v.push_back(int'(o_s_valid));
      q_l.push_back(int'(o_s_last));
    end
  end

  task automatic q_clear();
    q_s.delete(); q_v.delete(); q_l.delete();
  endtask

  task automatic dlv(input string tag, input int i,
                     input logic [7:0] s,
                     input int v, input int l);
    logic [7:0] gs;
    int gv, gl;
    gs = 'x; gv = -1; gl = -1;
    if (i < q_s.size()) begin
      gs = q_s[i]; gv = q_v[i]; gl = q_l[i];
    end
    check({tag, "_s"}, gs, s);
    check({tag, "_v"}, gv, v);
    check({tag, "_l"}, gl, l);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic pulse_req();
    i_request = 1'b1;
    @(negedge clk);
    i_request = 1'b0;
  endtask

  task automatic send(input logic [1:0] b,
                      input logic l);
    int k;
    k = 0;
    i_base_valid = 1'b1;
    i_base = b;
    i_base_last = l;
    while (!o_base_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!o_base_ready)
      check("send_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    i_base_valid = 1'b0;
    i_base_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (o_busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (o_busy) check({tag, "_timeout"}, 1, 0);
    repeat (2) @(negedge clk);
  endtask

  logic [1:0] seq1 [10];
  logic [1:0] seq2 [8];

  initial begin
    seq1 = '{0, 1, 2, 3, 3, 2, 1, 0, 1, 1};
    seq2 = '{3, 3, 3, 3, 0, 1, 2, 3};
    rst_n = 1'b0;
    i_start = 0; i_base_valid = 0;
    i_base = 0; i_base_last = 0; i_request = 0;
    w_start = 0; w_valid = 0;
    w_base = 0; w_last = 0; w_request = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", o_base_ready, 0);
    check("rst_s", o_s, 0);
    check("rst_valid", o_s_valid, 0);
    check("rst_last", o_s_last, 0);
    check("rst_busy", o_busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ten bases, spaced requests
    q_clear();
    pulse_start();
    check("t1_busy", o_busy, 1);
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(seq1[i], i == 9);
      end
      begin
        for (int r = 0; r < 3; r++) begin
          pulse_req();
          repeat (7) @(negedge clk);
        end
      end
    join
    wait_idle("t1");
    check("t1_n", q_s.size(), 3);
    dlv("t1_d0", 0, 8'h1B, 4, 0);
    dlv("t1_d1", 1, 8'hE4, 4, 0);
    dlv("t1_d2", 2, 8'h50, 2, 1);
    check("t1_idle", o_busy, 0);

    // 2: exactly two chunks, third request dropped
    q_clear();
    pulse_start();
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(seq2[i], i == 7);
      end
      begin
        for (int r = 0; r < 3; r++) begin
          pulse_req();
          repeat (7) @(negedge clk);
        end
      end
    join
    repeat (4) @(negedge clk);
    check("t2_n", q_s.size(), 2);
    dlv("t2_d0", 0, 8'hFF, 4, 0);
    dlv("t2_d1", 1, 8'h1B, 4, 1);
    check("t2_idle", o_busy, 0);

    // 3: backpressure with both entries full
    q_clear();
    pulse_start();
    for (int i = 0; i < 8; i++)
      send(seq1[i], 1'b0);
    check("t3_ready_low", o_base_ready, 0);
    repeat (2) @(negedge clk);
    check("t3_ready_hold", o_base_ready, 0);
    check("t3_none", q_s.size(), 0);
    pulse_req();
    check("t3_dlv_v", o_s_valid, 4);
    check("t3_ready_back", o_base_ready, 1);
    send(seq1[8], 1'b0);
    send(seq1[9], 1'b1);
    i_request = 1'b1;
    wait_idle("t3");
    i_request = 1'b0;
    check("t3_n", q_s.size(), 3);
    dlv("t3_d0", 0, 8'h1B, 4, 0);
    dlv("t3_d1", 1, 8'hE4, 4, 0);
    dlv("t3_d2", 2, 8'h50, 2, 1);

    // 4: request held before any data
    q_clear();
    pulse_start();
    i_request = 1'b1;
    for (int i = 0; i < 4; i++)
      send(seq1[i], 1'b0);
    check("t4_not_early", o_s_valid, 0);
    @(negedge clk);
    check("t4_lat_v", o_s_valid, 4);
    check("t4_lat_s", o_s, 8'h1B);
    send(2'd2, 1'b0);
    send(2'd2, 1'b1);
    wait_idle("t4");
    i_request = 1'b0;
    check("t4_n", q_s.size(), 2);
    dlv("t4_d1", 1, 8'hA0, 2, 1);

    // 5: single base, stray starts while busy
    q_clear();
    pulse_start();
    pulse_start();
    send(2'd2, 1'b1);
    pulse_start();
    repeat (2) @(negedge clk);
    check("t5_busy_hold", o_busy, 1);
    check("t5_none", q_s.size(), 0);
    pulse_req();
    wait_idle("t5");
    check("t5_n", q_s.size(), 1);
    dlv("t5_d0", 0, 8'h80, 1, 1);

    // 6: async reset mid-fill
    q_clear();
    pulse_start();
    for (int i = 0; i < 5; i++)
      send(seq1[i], 1'b0);
    check("t6_pre_s", o_s, 8'h80);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_s", o_s, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_ready", o_base_ready, 0);
    check("t6_rst_valid", o_s_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    send(2'd1, 1'b1);
    pulse_req();
    wait_idle("t6");
    check("t6_n", q_s.size(), 1);
    dlv("t6_d0", 0, 8'h40, 1, 1);

    // N=64: three bases packed at the top
    w_start = 1'b1;
    @(negedge clk);
    w_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_valid = 1'b1;
      w_base = (i == 0) ? 2'd3 :
               (i == 1) ? 2'd0 : 2'd1;
      w_last = (i == 2);
      check("w_ready", w_ready, 1);
      @(negedge clk);
    end
    w_valid = 1'b0;
    w_last = 1'b0;
    w_request = 1'b1;
    @(negedge clk);
    w_request = 1'b0;
    check("w_s", w_s, {6'b110001, 122'd0});
    check("w_v", w_s_valid, 3);
    check("w_l", w_s_last, 1);
    check("w_idle", w_busy, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
